// File: rtl/seq_detect_param.sv
// Serial pattern detector: programmable pattern/length, overlap mode, saturating match count.
// dout is registered and asserts on the edge that consumes the completing sample.
module seq_detect_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed,
  output logic             cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_n;
  logic             overlap;
  logic             match;
  logic             len_ok;

  // Only the low len bits of history take part in the compare.
  always_comb begin
    hist_n = {hist[PAT_W-2:0], din};
    fill_n = (fill < len) ? fill + ONE_LEN : len;
    mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    match  = (fill_n == len) && (((hist_n ^ pattern) & mask) == '0);
    len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      dout      <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      pattern   <= '0;
      len       <= ONE_LEN;
      overlap   <= 1'b0;
    end else if (cfg_load) begin
      // A load wins over a same-edge sample; that din bit is dropped.
      dout      <= 1'b0;
      match_cnt <= '0;
      if (len_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        cfg_err <= 1'b0;
        state   <= RUN;
        armed   <= 1'b1;
      end else begin
        cfg_err <= 1'b1;
        state   <= IDLE;
        armed   <= 1'b0;
      end
    end else if (state == RUN && en) begin
      hist <= hist_n;
      dout <= match;
      if (match) begin
        fill <= overlap ? fill_n : '0;
        if (match_cnt != '1) begin
          match_cnt <= match_cnt + 1'b1;
        end
      end else begin
        fill <= fill_n;
      end
    end else begin
      dout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: driver queues expected outputs per edge, monitor checks on negedge.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = 4'd1;
  logic       cfg_overlap = 1'b0;
  logic       dout, armed, cfg_err;
  logic [7:0] match_cnt;
  logic       dout2, armed2, cfg_err2;
  logic [1:0] match_cnt2;

  typedef struct packed {
    logic       dout;
    logic [7:0] cnt;
    logic       armed;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_armed = 1'b0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .dout(dout), .match_cnt(match_cnt), .armed(armed), .cfg_err(cfg_err)
  );

  // Narrow-counter copy on the same stimulus to exercise saturation.
  seq_detect_param #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .dout(dout2), .match_cnt(match_cnt2), .armed(armed2), .cfg_err(cfg_err2)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [1:0] e2;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        e2 = (e.cnt > 8'd3) ? 2'd3 : e.cnt[1:0];
        chk("dout", int'(dout), int'(e.dout));
        chk("match_cnt", int'(match_cnt), int'(e.cnt));
        chk("armed", int'(armed), int'(e.armed));
        chk("cfg_err", int'(cfg_err), int'(e.err));
        chk("dout_w2", int'(dout2), int'(e.dout));
        chk("match_cnt_w2", int'(match_cnt2), int'(e2));
      end
    end
  end

  task automatic step(input logic r, input logic ld, input logic e, input logic d,
                      input logic x_dout, input logic [7:0] x_cnt,
                      input logic x_armed, input logic x_err);
    exp_t x;
    rst = r; cfg_load = ld; en = e; din = d;
    @(posedge clk);
    x.dout = x_dout; x.cnt = x_cnt; x.armed = x_armed; x.err = x_err;
    q.push_back(x);
    @(negedge clk);
    rst = 1'b1; cfg_load = 1'b0; en = 1'b0;
  endtask

  task automatic smp(input logic e, input logic d, input logic x_dout, input logic [7:0] x_cnt);
    step(1'b1, 1'b0, e, d, x_dout, x_cnt, exp_armed, exp_err);
  endtask

  // Load always comes with en=1, din=1 so the same-edge sample must be dropped.
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    logic legal;
    legal = (len >= 4'd1) && (len <= 4'd8);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, legal, !legal);
    exp_armed = legal;
    exp_err   = !legal;
  endtask

  // Reset asserted alongside a legal load and a sample: reset must win.
  task automatic reset_cyc();
    cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    exp_armed = 1'b0;
    exp_err   = 1'b0;
  endtask

  initial begin : driver
    logic [6:0] s1011;
    logic [6:0] d1011_ov;
    logic [7:0] c1011_ov [7];
    @(negedge clk);
    reset_cyc();
    reset_cyc();
    smp(1'b1, 1'b1, 1'b0, 8'd0);            // IDLE ignores samples

    // 111, non-overlapping: pulses on samples 3 and 6
    load(8'b111, 4'd3, 1'b0);
    smp(1, 1, 0, 0); smp(1, 1, 0, 0); smp(1, 1, 1, 1);
    smp(1, 1, 0, 1); smp(1, 1, 0, 1); smp(1, 1, 1, 2);

    // 111, overlapping: pulses on samples 3, 4, 5
    load(8'b111, 4'd3, 1'b1);
    smp(1, 1, 0, 0); smp(1, 1, 0, 0); smp(1, 1, 1, 1);
    smp(1, 1, 1, 2); smp(1, 1, 1, 3);

    // 1011 overlapping on stream 1,0,1,1,0,1,1
    s1011    = 7'b1011011;
    d1011_ov = 7'b0001001;
    c1011_ov = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
    load(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) smp(1'b1, s1011[6-i], d1011_ov[6-i], c1011_ov[i]);

    // same, non-overlapping: only sample 4
    load(8'b1011, 4'd4, 1'b0);
    smp(1, 1, 0, 0); smp(1, 0, 0, 0); smp(1, 1, 0, 0); smp(1, 1, 1, 1);
    smp(1, 0, 0, 1); smp(1, 1, 0, 1); smp(1, 1, 0, 1);

    // reset mid-sequence discards partial match
    load(8'b111, 4'd3, 1'b0);
    smp(1, 1, 0, 0); smp(1, 1, 0, 0);
    reset_cyc();
    smp(1, 1, 0, 0);
    load(8'b111, 4'd3, 1'b0);
    smp(1, 1, 0, 0);

    // illegal lengths clear the count and park in IDLE
    load(8'b1, 4'd1, 1'b0);
    smp(1, 1, 1, 1);
    load(8'b0, 4'd0, 1'b0);
    smp(1, 1, 0, 0); smp(1, 1, 0, 0); smp(1, 1, 0, 0);
    load(8'hFF, 4'd9, 1'b1);
    smp(1, 1, 0, 0);
    load(8'b111, 4'd3, 1'b0);
    smp(1, 1, 0, 0); smp(1, 1, 0, 0); smp(1, 1, 1, 1);

    // en=0 holds history even when din toggles
    load(8'b111, 4'd3, 1'b1);
    smp(1, 1, 0, 0); smp(0, 0, 0, 0); smp(1, 1, 0, 0);
    smp(0, 0, 0, 0); smp(1, 1, 1, 1); smp(0, 1, 0, 1);

    // len 1, pattern 0: every 0 sample matches
    load(8'b0, 4'd1, 1'b1);
    smp(1, 0, 1, 1); smp(1, 1, 0, 1); smp(1, 0, 1, 2);

    // len 1, pattern 1, interleaved en: narrow counter saturates at 3
    load(8'b1, 4'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      smp(1'b1, 1'b1, 1'b1, 8'(i + 1));
      smp(1'b0, 1'b1, 1'b0, 8'(i + 1));
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
